// File: rtl/module_output_enco_gray.sv
`default_nettype none
// ============================================================================
//  Module   : module_output_enco_gray
//  Brief    : Binary-to-Gray encoder with a rate-limited registered output.
//             Accepts a binary code over valid/ready or steps an internal
//             counter up/down, and publishes its Gray equivalent at most
//             once per output refresh period.
//  Revision : 1.0 - initial release
// ============================================================================
module module_output_enco_gray #(
   parameter int WIDTH          = 4,
   parameter int OUTPUT_REFRESH = 2700000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] codigo_bin_i,
   input  logic             bin_valid_i,
   output logic             bin_ready_o,
   input  logic             mode_i,
   input  logic             dir_i,
   output logic [WIDTH-1:0] codigo_gray_o,
   output logic             gray_valid_o
);

   localparam int                CNT_W      = $clog2(OUTPUT_REFRESH);
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(OUTPUT_REFRESH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_AUTO = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [WIDTH-1:0]   gray_q, gray_d;
   logic               gray_valid_q, gray_valid_d;
   logic [CNT_W-1:0]   cuenta_salida_q, cuenta_salida_d;
   logic               tick_q, tick_d;
   logic [WIDTH-1:0]   step_val;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Ready only when idle in load mode and not being reset.
   assign bin_ready_o   = (state_q == S_IDLE) && !mode_i && !rst_i;
   assign codigo_gray_o = gray_q;
   assign gray_valid_o  = gray_valid_q;

   // Free-running refresh divider: one-cycle tick each time the count hits zero.
   always_comb begin
      cuenta_salida_d = cuenta_salida_q - CNT_W'(1);
      tick_d          = 1'b0;
      if (cuenta_salida_q == '0) begin
         cuenta_salida_d = C_CNT_LOAD;
         tick_d          = 1'b1;
      end
   end

   // Next-state logic: accept codes, publish on tick, or step the counter.
   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      gray_d       = gray_q;
      gray_valid_d = 1'b0;
      step_val     = dir_i ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
      case (state_q)
         S_IDLE: begin
            if (bin_valid_i && bin_ready_o) begin
               bin_d   = codigo_bin_i;
               state_d = S_PEND;
            end else if (mode_i) begin
               // bin_q is kept and seeds the auto count
               state_d = S_AUTO;
            end
         end
         S_PEND: begin
            // mode_i is deliberately ignored until the pending code goes out
            if (tick_q) begin
               gray_d       = to_gray(bin_q);
               gray_valid_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_AUTO: begin
            // Leaving auto mode wins over a coincident tick: no step taken
            if (!mode_i) begin
               state_d = S_IDLE;
            end else if (tick_q) begin
               bin_d        = step_val;
               gray_d       = to_gray(step_val);
               gray_valid_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= S_IDLE;
         bin_q           <= '0;
         gray_q          <= '0;
         gray_valid_q    <= 1'b0;
         cuenta_salida_q <= C_CNT_LOAD;
         tick_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         bin_q           <= bin_d;
         gray_q          <= gray_d;
         gray_valid_q    <= gray_valid_d;
         cuenta_salida_q <= cuenta_salida_d;
         tick_q          <= tick_d;
      end
   end

endmodule
`default_nettype wire
